// File: rtl/trace_packet_decoder.sv
// Decodes trace packets from an AXI-Stream beat into instruction, PC, absolute
// timestamp and performance counters, with per-frame bookkeeping.
module trace_packet_decoder #(
    parameter int PERF_CTR_WIDTH           = 16,
    parameter int NO_OF_EVENTS             = 4,
    parameter bit HALT_ON_TLAST            = 1'b1,
    parameter int RISC_V_INSTRUCTION_WIDTH = 32,
    parameter int XLEN                     = 32,
    parameter int CLK_COUNTER_WIDTH        = 64,
    parameter int CLK_DELTA_WIDTH          = 32,
    localparam int CTRS_WIDTH              = NO_OF_EVENTS * PERF_CTR_WIDTH,
    localparam int AXI_DATA_WIDTH          = RISC_V_INSTRUCTION_WIDTH + CLK_DELTA_WIDTH + XLEN + CTRS_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                S_AXIS_tvalid,
    output logic                                S_AXIS_tready,
    input  logic [AXI_DATA_WIDTH-1:0]           S_AXIS_tdata,
    input  logic                                S_AXIS_tlast,
    input  logic                                restart,
    input  logic [CLK_COUNTER_WIDTH-1:0]        timestamp_base,
    input  logic [31:0]                         tlast_interval,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [RISC_V_INSTRUCTION_WIDTH-1:0] out_instr,
    output logic [XLEN-1:0]                     out_pc,
    output logic [CLK_COUNTER_WIDTH-1:0]        out_timestamp,
    output logic [CTRS_WIDTH-1:0]               out_ctrs,
    output logic                                out_last,
    output logic [31:0]                         frame_count,
    output logic [31:0]                         pkt_in_frame,
    output logic                                frame_overlong,
    output logic [1:0]                          state
);

    localparam int PC_LSB    = CTRS_WIDTH;
    localparam int DELTA_LSB = PC_LSB + XLEN;
    localparam int INSTR_LSB = DELTA_LSB + CLK_DELTA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t                         state_q;
    state_t                         state_d;
    logic [CLK_COUNTER_WIDTH-1:0]   ts;
    logic [CLK_COUNTER_WIDTH-1:0]   ts_base;
    logic [CLK_COUNTER_WIDTH-1:0]   ts_next;
    logic [CLK_DELTA_WIDTH-1:0]     clk_delta;
    logic [31:0]                    pkt_next;
    logic                           accept;

    assign S_AXIS_tready = rst_n & ~restart & (state_q != ST_HALTED) & (~out_valid | out_ready);
    assign accept        = S_AXIS_tvalid & S_AXIS_tready;
    assign state         = state_q;

    // The first packet of a frame counts from the externally supplied base time.
    assign clk_delta = S_AXIS_tdata[DELTA_LSB +: CLK_DELTA_WIDTH];
    assign ts_base   = (state_q == ST_IDLE) ? timestamp_base : ts;
    assign ts_next   = ts_base + CLK_COUNTER_WIDTH'(clk_delta);
    assign pkt_next  = (pkt_in_frame == 32'hFFFF_FFFF) ? pkt_in_frame : pkt_in_frame + 32'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = ST_IDLE;
        end else if (accept) begin
            if (S_AXIS_tlast) begin
                state_d = HALT_ON_TLAST ? ST_HALTED : ST_IDLE;
            end else begin
                state_d = ST_STREAM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts             <= timestamp_base;
            frame_count    <= '0;
            pkt_in_frame   <= '0;
            frame_overlong <= 1'b0;
            out_valid      <= 1'b0;
            out_instr      <= '0;
            out_pc         <= '0;
            out_timestamp  <= '0;
            out_ctrs       <= '0;
            out_last       <= 1'b0;
        end else begin
            if (restart) begin
                ts             <= timestamp_base;
                pkt_in_frame   <= '0;
                frame_overlong <= 1'b0;
            end else if (accept) begin
                ts <= ts_next;
                if (S_AXIS_tlast) begin
                    if (frame_count != 32'hFFFF_FFFF) begin
                        frame_count <= frame_count + 32'd1;
                    end
                    pkt_in_frame <= '0;
                end else begin
                    pkt_in_frame <= pkt_next;
                    if ((tlast_interval != 32'd0) && (pkt_next >= tlast_interval)) begin
                        frame_overlong <= 1'b1;
                    end
                end
            end

            // Restart never coincides with an accept, so a pending record survives it.
            if (accept) begin
                out_valid     <= 1'b1;
                out_instr     <= S_AXIS_tdata[INSTR_LSB +: RISC_V_INSTRUCTION_WIDTH];
                out_pc        <= S_AXIS_tdata[PC_LSB +: XLEN];
                out_ctrs      <= S_AXIS_tdata[0 +: CTRS_WIDTH];
                out_timestamp <= ts_next;
                out_last      <= S_AXIS_tlast;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trace_packet_decoder.sv
// Randomised scoreboard bench for trace_packet_decoder; a reference model predicts
// records and status, a negedge monitor compares whenever a record is presented.
module tb_trace_packet_decoder;

    localparam int IW  = 32;
    localparam int XL  = 32;
    localparam int CW  = 64;
    localparam int DW  = 32;
    localparam int PW  = 16;
    localparam int NE  = 4;
    localparam int CTW = PW * NE;
    localparam int AW  = IW + DW + XL + CTW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           S_AXIS_tvalid = 1'b0;
    logic           S_AXIS_tready;
    logic [AW-1:0]  S_AXIS_tdata = '0;
    logic           S_AXIS_tlast = 1'b0;
    logic           restart = 1'b0;
    logic [CW-1:0]  timestamp_base = '0;
    logic [31:0]    tlast_interval = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [IW-1:0]  out_instr;
    logic [XL-1:0]  out_pc;
    logic [CW-1:0]  out_timestamp;
    logic [CTW-1:0] out_ctrs;
    logic           out_last;
    logic [31:0]    frame_count;
    logic [31:0]    pkt_in_frame;
    logic           frame_overlong;
    logic [1:0]     state;

    always #5 clk = ~clk;

    trace_packet_decoder #(
        .PERF_CTR_WIDTH(PW), .NO_OF_EVENTS(NE), .HALT_ON_TLAST(1'b1),
        .RISC_V_INSTRUCTION_WIDTH(IW), .XLEN(XL), .CLK_COUNTER_WIDTH(CW), .CLK_DELTA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tready(S_AXIS_tready),
        .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tlast(S_AXIS_tlast),
        .restart(restart), .timestamp_base(timestamp_base), .tlast_interval(tlast_interval),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_timestamp(out_timestamp),
        .out_ctrs(out_ctrs), .out_last(out_last),
        .frame_count(frame_count), .pkt_in_frame(pkt_in_frame),
        .frame_overlong(frame_overlong), .state(state)
    );

    typedef struct {
        logic [IW-1:0]  instr;
        logic [XL-1:0]  pc;
        logic [CW-1:0]  ts;
        logic [CTW-1:0] ctrs;
        logic           last;
    } rec_t;

    rec_t          exp_q[$];
    logic [CW-1:0] m_ts = '0;
    bit            m_started = 1'b0;
    bit            m_halted = 1'b0;
    logic [31:0]   m_frames = '0;
    logic [31:0]   m_pkts = '0;
    bit            m_overlong = 1'b0;
    bit            m_data_zero = 1'b1;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check_output(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check tready, then advance the model past the edge.
    task automatic apply_stimulus(input bit rst, input bit tv, input bit tl, input bit ordy,
                                  input bit rs, input logic [DW-1:0] delta);
        logic [IW-1:0]  instr;
        logic [XL-1:0]  pc;
        logic [CTW-1:0] ctrs;
        logic [CW-1:0]  base;
        bit             exp_rdy;
        rec_t           r;
        instr = $urandom;
        pc    = $urandom;
        ctrs  = {$urandom, $urandom};
        rst_n         = rst;
        S_AXIS_tvalid = tv;
        S_AXIS_tlast  = tl;
        out_ready     = ordy;
        restart       = rs;
        S_AXIS_tdata  = {instr, delta, pc, ctrs};
        #1;
        exp_rdy = rst && !rs && !m_halted && ((exp_q.size() == 0) || ordy);
        check_output("tready", 160'(S_AXIS_tready), 160'(exp_rdy));
        @(posedge clk);
        #1;
        if (!rst) begin
            exp_q.delete();
            m_ts = timestamp_base; m_started = 0; m_halted = 0; m_frames = 0;
            m_pkts = 0; m_overlong = 0; m_data_zero = 1;
        end else if (rs) begin
            m_ts = timestamp_base; m_started = 0; m_halted = 0; m_pkts = 0; m_overlong = 0;
        end else if (tv && exp_rdy) begin
            base = m_started ? m_ts : timestamp_base;
            m_ts = base + CW'(delta);
            r.instr = instr; r.pc = pc; r.ctrs = ctrs; r.ts = m_ts; r.last = tl;
            exp_q.push_back(r);
            m_data_zero = 0;
            if (tl) begin
                if (m_frames != 32'hFFFF_FFFF) m_frames++;
                m_pkts = 0;
                m_started = 0;
                m_halted = 1;
            end else begin
                if (m_pkts != 32'hFFFF_FFFF) m_pkts++;
                m_started = 1;
                if ((tlast_interval != 0) && (m_pkts >= tlast_interval)) m_overlong = 1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check_output("out_valid", 160'(out_valid), 160'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check_output("out_instr", 160'(out_instr), 160'(exp_q[0].instr));
                check_output("out_pc", 160'(out_pc), 160'(exp_q[0].pc));
                check_output("out_timestamp", 160'(out_timestamp), 160'(exp_q[0].ts));
                check_output("out_ctrs", 160'(out_ctrs), 160'(exp_q[0].ctrs));
                check_output("out_last", 160'(out_last), 160'(exp_q[0].last));
                if (out_ready) void'(exp_q.pop_front());
            end else if (m_data_zero) begin
                check_output("reset_data", 160'({out_instr, out_pc, out_timestamp, out_ctrs, out_last}), 160'(0));
            end
            check_output("state", 160'(state), 160'(m_halted ? 2 : (m_started ? 1 : 0)));
            check_output("frame_count", 160'(frame_count), 160'(m_frames));
            check_output("pkt_in_frame", 160'(pkt_in_frame), 160'(m_pkts));
            check_output("frame_overlong", 160'(frame_overlong), 160'(m_overlong));
        end
    end

    initial begin
        timestamp_base = 64'd1000;
        tlast_interval = 32'd0;
        apply_stimulus(0, 0, 0, 1, 0, 0);
        apply_stimulus(0, 1, 0, 1, 0, 0);
        apply_stimulus(1, 0, 0, 1, 0, 0);

        // Timestamps 1005, 1008, 1015 with a free-flowing sink.
        apply_stimulus(1, 1, 0, 1, 0, 5);
        apply_stimulus(1, 1, 0, 1, 0, 3);
        apply_stimulus(1, 1, 0, 1, 0, 7);
        apply_stimulus(1, 0, 0, 1, 0, 0);

        // Sink stalls for four cycles with a continuously valid source.
        for (int i = 0; i < 4; i++) apply_stimulus(1, 1, 0, 0, 0, 11);
        for (int i = 0; i < 3; i++) apply_stimulus(1, 1, 0, 1, 0, 2);

        // Third beat of a fresh frame carries tlast and halts the decoder.
        apply_stimulus(1, 0, 0, 1, 1, 0);
        apply_stimulus(1, 1, 0, 1, 0, 4);
        apply_stimulus(1, 1, 0, 1, 0, 4);
        apply_stimulus(1, 1, 1, 1, 0, 4);
        for (int i = 0; i < 3; i++) apply_stimulus(1, 1, 0, 1, 0, 9);
        apply_stimulus(1, 0, 0, 1, 1, 0);
        apply_stimulus(1, 1, 0, 1, 0, 6);

        // Timestamp wraps: base 2^64-2 plus 5 gives 3.
        timestamp_base = 64'hFFFF_FFFF_FFFF_FFFE;
        apply_stimulus(1, 0, 0, 1, 1, 0);
        apply_stimulus(1, 1, 0, 1, 0, 5);
        apply_stimulus(1, 1, 0, 1, 0, 2);

        // Overlong frame with an interval of two, cleared by restart.
        timestamp_base = 64'd500;
        tlast_interval = 32'd2;
        apply_stimulus(1, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(1, 1, 0, 1, 0, 1);
        apply_stimulus(1, 0, 0, 1, 0, 0);

        // Restart coincident with a valid beat.
        apply_stimulus(1, 1, 0, 1, 1, 8);
        apply_stimulus(1, 1, 0, 1, 0, 8);

        for (int i = 0; i < 800; i++) begin
            bit rs;
            rs = ($urandom_range(99) < 3);
            if (rs && $urandom_range(1) == 1) timestamp_base = {$urandom, $urandom};
            if (i % 100 == 0) tlast_interval = $urandom_range(5);
            apply_stimulus($urandom_range(99) != 0, $urandom_range(9) < 7, $urandom_range(9) == 0,
                           $urandom_range(9) < 7, rs, DW'($urandom_range(1000)));
        end
        for (int i = 0; i < 4; i++) apply_stimulus(1, 0, 0, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
